// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper and its BCD arithmetic helper.
// Scores are two packed BCD digits {tens, ones}.
package score_pkg;

    typedef logic [3:0] bcdDigit_t;
    typedef logic [7:0] bcdScore_t;
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t PLAY  = 2'd1;
    localparam state_t MAXED = 2'd2;

    localparam bcdScore_t BCD_ZERO      = 8'h00;
    localparam bcdDigit_t DEF_STEP_UP   = 4'd1;
    localparam bcdDigit_t DEF_STEP_DOWN = 4'd1;
    localparam bcdScore_t DEF_MAX_SCORE = 8'h99;

endpackage

// File: rtl/score_keeper_bcd_step.sv
// Combinational BCD step: applies (add - sub) to a 2-digit BCD score with
// per-digit carry/borrow, clamping to [00, max] and flagging any clamp.
module bcd_step
    import score_pkg::*;
(
    input  bcdScore_t score,
    input  bcdDigit_t add,
    input  bcdDigit_t sub,
    input  bcdScore_t max,
    output bcdScore_t result,
    output logic      clipped
);

    // Returns {clipped, score}; tens below 0 or above 9 means the digit chain over/underflowed.
    function automatic logic [8:0] saturate(
        input logic signed [5:0] tens,
        input logic signed [5:0] ones,
        input bcdScore_t         lim
    );
        bcdScore_t cand;
        cand = {tens[3:0], ones[3:0]};
        if (tens < 6'sd0) return {1'b1, BCD_ZERO};
        if (tens > 6'sd9 || cand > lim) return {1'b1, lim};
        return {1'b0, cand};
    endfunction

    logic signed [5:0] stepNet;
    logic signed [5:0] onesRaw;
    logic signed [5:0] onesAdj;
    logic signed [5:0] tensAdj;

    always_comb begin
        stepNet = $signed({2'b00, add}) - $signed({2'b00, sub});
        onesRaw = $signed({2'b00, score[3:0]}) + stepNet;
        onesAdj = onesRaw;
        tensAdj = $signed({2'b00, score[7:4]});
        if (onesRaw > 6'sd9) begin
            onesAdj = onesRaw - 6'sd10;
            tensAdj = tensAdj + 6'sd1;
        end else if (onesRaw < 6'sd0) begin
            onesAdj = onesRaw + 6'sd10;
            tensAdj = tensAdj - 6'sd1;
        end
        {clipped, result} = saturate(tensAdj, onesAdj, max);
    end

endmodule

// File: rtl/score_keeper.sv
// Running score and session high score in BCD, driven by rising edges of the
// game controller's scoreUp / scoreDown / scoreRst requests.
module score_keeper
    import score_pkg::*;
#(
    parameter bcdDigit_t STEP_UP   = DEF_STEP_UP,
    parameter bcdDigit_t STEP_DOWN = DEF_STEP_DOWN,
    parameter bcdScore_t MAX_SCORE = DEF_MAX_SCORE
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      scoreUp,
    input  logic      scoreDown,
    input  logic      scoreRst,
    output bcdScore_t currentScore,
    output bcdScore_t highScore,
    output logic      newHigh,
    output logic      satPulse
);

    logic      upPrev;
    logic      downPrev;
    logic      rstPrev;
    logic      armed;
    logic      evUp;
    logic      evDown;
    logic      evRst;
    logic      evStep;
    bcdDigit_t stepAdd;
    bcdDigit_t stepSub;
    bcdScore_t stepResult;
    logic      stepClipped;
    state_t    state;
    state_t    nextState;

    // armed stays low for the first edge after reset so a request held across release is not an event
    assign evUp    = armed & scoreUp   & ~upPrev;
    assign evDown  = armed & scoreDown & ~downPrev;
    assign evRst   = armed & scoreRst  & ~rstPrev;
    assign evStep  = (evUp | evDown) & ~evRst;
    assign stepAdd = evUp   ? STEP_UP   : 4'd0;
    assign stepSub = evDown ? STEP_DOWN : 4'd0;

    bcd_step uStep (
        .score   (currentScore),
        .add     (stepAdd),
        .sub     (stepSub),
        .max     (MAX_SCORE),
        .result  (stepResult),
        .clipped (stepClipped)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE, PLAY: if (evStep) nextState = (stepResult == MAX_SCORE) ? MAXED : PLAY;
            MAXED:      if (evDown) nextState = (stepResult == MAX_SCORE) ? MAXED : PLAY;
            default:    nextState = IDLE;
        endcase
        if (evRst) nextState = IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            upPrev       <= 1'b0;
            downPrev     <= 1'b0;
            rstPrev      <= 1'b0;
            armed        <= 1'b0;
            state        <= IDLE;
            currentScore <= BCD_ZERO;
            highScore    <= BCD_ZERO;
            newHigh      <= 1'b0;
            satPulse     <= 1'b0;
        end else begin
            upPrev   <= scoreUp;
            downPrev <= scoreDown;
            rstPrev  <= scoreRst;
            armed    <= 1'b1;
            state    <= nextState;
            satPulse <= evStep & stepClipped;
            if (evRst) begin
                currentScore <= BCD_ZERO;
                newHigh      <= 1'b0;
            end else begin
                if (evStep) currentScore <= stepResult;
                if (currentScore > highScore) newHigh <= 1'b1;
            end
            // high score follows the registered current score one edge later
            if (currentScore > highScore) highScore <= currentScore;
        end
    end

endmodule
